controlador_acumulador: RTL
===========================

CONTROLADOR_ACUMULADOR -- requirements
Module: controlador_acumulador

Interface
REQ-001 The block SHALL have exactly one clock and one reset; reset is synchronous and active-low.
REQ-002 Clock  in  1  system clock; all state updates on rising edge.
REQ-003 Reset_n  in  1  synchronous active-low reset.
REQ-004 Start  in  1  request a sum; sampled only in IDLE.
REQ-005 Base_Addr  in  8  first memory address; latched when Start is accepted.
REQ-006 Len  in  8  number of 16-bit words to sum (0..255); latched when Start is accepted.
REQ-007 Mem_Rd  out  1  memory read strobe.
REQ-008 Mem_Addr  out  8  memory read address.
REQ-009 Mem_Data  in  16  read data, valid in the cycle after Mem_Rd.
REQ-010 Acc_DataIN  out  16  word presented to the accumulator B register.
REQ-011 Acc_Load  out  1  one-cycle strobe that loads Acc_DataIN into B.
REQ-012 Acc_Transfer  out  1  one-cycle strobe that writes A+B into A.
REQ-013 Acc_Clear  out  1  one-cycle strobe that clears A.
REQ-014 Acc_DataOut  in  16  accumulator A value.
REQ-015 Busy  out  1  high from the CLR cycle through the FIN cycle inclusive.
REQ-016 Done  out  1  one-cycle pulse; Result and Ovf are valid in that cycle.
REQ-017 Result  out  16  latched final sum; held until the next FIN.
REQ-018 Ovf  out  1  sticky unsigned-wrap flag for the last run; held with Result.

Function
REQ-019 The FSM SHALL have states IDLE, CLR, RD, CAP, LD, XFER and FIN.
REQ-020 IDLE with Start=1 SHALL go to CLR, latch Base_Addr and Len, and zero the word counter and the internal Ovf flag.
REQ-021 CLR SHALL assert Acc_Clear, then go to FIN if Len==0, else to RD.
REQ-022 RD SHALL assert Mem_Rd with Mem_Addr = base + index (8-bit, wraps 0xFF->0x00), then go to CAP.
REQ-023 CAP SHALL register Mem_Data into the hold register driving Acc_DataIN, then go to LD.
REQ-024 LD SHALL assert Acc_Load with Acc_DataIN stable, then go to XFER.
REQ-025 XFER SHALL assert Acc_Transfer, then go to FIN if index==Len-1, else increment index and go to RD.
REQ-026 In the cycle after each XFER (RD or FIN), if Acc_DataOut < hold register (unsigned), the internal Ovf flag SHALL be set; it is sticky until the next accepted Start.
REQ-027 FIN SHALL capture Acc_DataOut into Result and the internal flag into Ovf, then go to IDLE; Done SHALL be 1 in the following IDLE cycle only.
REQ-028 Timing: with Start in cycle 0, CLR is cycle 1, word k occupies cycles 4k+2..4k+5, FIN is cycle 4*Len+2, and Done is cycle 4*Len+3.
REQ-029 Start outside IDLE SHALL be ignored; Start in the Done cycle SHALL be accepted, giving back-to-back runs.
REQ-030 Acc_Load, Acc_Transfer, Acc_Clear, Mem_Rd and Busy SHALL be driven directly from flops (glitch-free, because the accumulator uses the strobes as clocks), and at most one strobe SHALL be high in any cycle.
REQ-031 Mem_Addr and Acc_DataIN SHALL be held stable outside RD and LD respectively.

Reset
REQ-032 Reset_n=0 at a clock edge SHALL force IDLE and drive all outputs to 0, including Result, Ovf and Acc_DataIN.
REQ-033 Reset mid-run SHALL abandon the run with no Done pulse; the first Start after release SHALL behave as from power-up.

Structure
REQ-034 State encodings, ADDR_W=8, DATA_W=16 and LEN_W=8 SHALL live in a shared package/include used by the controller and the bench.
REQ-035 The index/address counter MAY be a sub-module contador_palavras (load, increment, terminal-count); the FSM SHALL remain in controlador_acumulador.

Verification
REQ-036 Len=3, Base=0x10, mem[0x10..0x12]=1,2,3 -> Result=0x0006, Ovf=0, Done in cycle 15, Mem_Addr sequence 0x10,0x11,0x12.
REQ-037 Len=2, words 0xFFFF,0x0002 -> Result=0x0001, Ovf=1.
REQ-038 Len=0 -> one Acc_Clear, no Mem_Rd/Load/Transfer, Result=0x0000, Done in cycle 3.
REQ-039 Base=0xFE, Len=3 -> addresses 0xFE,0xFF,0x00.
REQ-040 Reset_n=0 during the second word's LD -> all outputs 0 next cycle, no Done; a new Start runs correctly.
REQ-041 Start held high through a run -> ignored while Busy; second run accepted in the Done cycle, strobe one-hot checked every cycle.

Source files
------------

// File: rtl/controlador_acumulador_pkg.sv
// Shared widths and FSM encoding for the accumulator controller and its bench.
package controlador_acumulador_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;
    localparam int LEN_W  = 8;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CLR  = 3'd1,
        S_RD   = 3'd2,
        S_CAP  = 3'd3,
        S_LD   = 3'd4,
        S_XFER = 3'd5,
        S_FIN  = 3'd6
    } state_t;

endpackage

// File: rtl/controlador_acumulador_contador_palavras.sv
// Word index counter: clears on run start, steps once per word, flags the last word.
// Single-cycle update; no backpressure (the FSM paces it).
module contador_palavras
    import controlador_acumulador_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    input  logic [LEN_W-1:0] last,
    output logic             tc
);

    logic [LEN_W-1:0] idx_q;
    logic [LEN_W-1:0] idx_d;

    always_comb begin
        idx_d = idx_q;
        if (clr) begin
            idx_d = '0;
        end else if (inc) begin
            idx_d = idx_q + LEN_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

    assign tc = (idx_q == last);

endmodule

// File: rtl/controlador_acumulador.sv
// Sums Len words from memory through an external A/B accumulator; 4 cycles per word, Done at 4*Len+3.
// Start is only taken in IDLE (including the Done cycle); all strobes are flop outputs, one-hot.
module controlador_acumulador
    import controlador_acumulador_pkg::*;
(
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic              Start,
    input  logic [ADDR_W-1:0] Base_Addr,
    input  logic [LEN_W-1:0]  Len,
    output logic              Mem_Rd,
    output logic [ADDR_W-1:0] Mem_Addr,
    input  logic [DATA_W-1:0] Mem_Data,
    output logic [DATA_W-1:0] Acc_DataIN,
    output logic              Acc_Load,
    output logic              Acc_Transfer,
    output logic              Acc_Clear,
    input  logic [DATA_W-1:0] Acc_DataOut,
    output logic              Busy,
    output logic              Done,
    output logic [DATA_W-1:0] Result,
    output logic              Ovf
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              ovf_flag_q, ovf_flag_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              ovf_q, ovf_d;
    logic              rd_q, ld_q, xfer_q, clr_q, busy_q, done_q, chk_q;
    logic              cnt_clr, cnt_inc, cnt_tc, wrap;

    contador_palavras u_contador (
        .clk   (Clock),
        .rst_n (Reset_n),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .last  (len_q - LEN_W'(1)),
        .tc    (cnt_tc)
    );

    // A new A smaller than the word just added means the sum wrapped.
    assign wrap = chk_q && (Acc_DataOut < hold_q);

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        len_d      = len_q;
        mem_addr_d = mem_addr_q;
        hold_d     = hold_q;
        ovf_flag_d = ovf_flag_q | wrap;
        result_d   = result_q;
        ovf_d      = ovf_q;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    state_d    = S_CLR;
                    base_d     = Base_Addr;
                    len_d      = Len;
                    ovf_flag_d = 1'b0;
                    cnt_clr    = 1'b1;
                end
            end
            S_CLR: begin
                if (len_q == '0) begin
                    state_d = S_FIN;
                end else begin
                    state_d    = S_RD;
                    mem_addr_d = base_q;
                end
            end
            S_RD:   state_d = S_CAP;
            S_CAP: begin
                hold_d  = Mem_Data;
                state_d = S_LD;
            end
            S_LD:   state_d = S_XFER;
            S_XFER: begin
                if (cnt_tc) begin
                    state_d = S_FIN;
                end else begin
                    state_d    = S_RD;
                    cnt_inc    = 1'b1;
                    mem_addr_d = mem_addr_q + ADDR_W'(1);
                end
            end
            S_FIN: begin
                result_d = Acc_DataOut;
                ovf_d    = ovf_flag_q | wrap;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Strobes are registered decodes of the next state so they leave flops cleanly.
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            state_q    <= S_IDLE;
            base_q     <= '0;
            len_q      <= '0;
            mem_addr_q <= '0;
            hold_q     <= '0;
            ovf_flag_q <= 1'b0;
            result_q   <= '0;
            ovf_q      <= 1'b0;
            rd_q       <= 1'b0;
            ld_q       <= 1'b0;
            xfer_q     <= 1'b0;
            clr_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            chk_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            len_q      <= len_d;
            mem_addr_q <= mem_addr_d;
            hold_q     <= hold_d;
            ovf_flag_q <= ovf_flag_d;
            result_q   <= result_d;
            ovf_q      <= ovf_d;
            rd_q       <= (state_d == S_RD);
            ld_q       <= (state_d == S_LD);
            xfer_q     <= (state_d == S_XFER);
            clr_q      <= (state_d == S_CLR);
            busy_q     <= (state_d != S_IDLE);
            done_q     <= (state_q == S_FIN);
            chk_q      <= (state_q == S_XFER);
        end
    end

    assign Mem_Rd       = rd_q;
    assign Mem_Addr     = mem_addr_q;
    assign Acc_DataIN   = hold_q;
    assign Acc_Load     = ld_q;
    assign Acc_Transfer = xfer_q;
    assign Acc_Clear    = clr_q;
    assign Busy         = busy_q;
    assign Done         = done_q;
    assign Result       = result_q;
    assign Ovf          = ovf_q;

endmodule
